// File: rtl/soc_adc_sample_proc.sv
// ADC sample post-processor: power-of-two block averaging, running min/max,
// hysteresis threshold alarm on each average and a sticky interrupt.
module soc_adc_sample_proc #(
    parameter int DW       = 10,
    parameter int MAX_LOG2 = 7
) (
    input  logic          sys_slow_cbus_clk,
    input  logic          sys_slow_cbus_rst_n,
    input  logic [DW-1:0] adc_data_in,
    input  logic          adc_strb_in,
    input  logic          cfg_en,
    input  logic [2:0]    cfg_avg_log2,
    input  logic [DW-1:0] cfg_thr_hi,
    input  logic [DW-1:0] cfg_thr_lo,
    input  logic          clr_minmax,
    input  logic          irq_clr,
    output logic [DW-1:0] avg_data,
    output logic          avg_valid,
    output logic [DW-1:0] min_data,
    output logic [DW-1:0] max_data,
    output logic          thr_alarm,
    output logic          irq
);

    localparam int ACC_W = DW + MAX_LOG2;
    localparam int CNT_W = MAX_LOG2 + 1;
    localparam int NL_W  = $clog2(MAX_LOG2 + 1) + 1;

    typedef enum logic {
        IDLE,
        ACC
    } avg_state_t;

    typedef enum logic {
        NORMAL,
        ALARM
    } thr_state_t;

    avg_state_t      avg_state_reg, avg_state_next;
    thr_state_t      thr_state_reg, thr_state_next;
    logic [ACC_W-1:0] acc_reg, acc_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [NL_W-1:0]  nlat_reg, nlat_next;
    logic [DW-1:0]    avg_data_reg, avg_data_next;
    logic             avg_valid_reg, avg_valid_next;
    logic [DW-1:0]    min_reg, min_next;
    logic [DW-1:0]    max_reg, max_next;
    logic             irq_reg, irq_next;

    logic [NL_W-1:0]  n_clip;
    logic [CNT_W-1:0] win_last;
    logic [ACC_W-1:0] sum;

    // Requested exponent clipped to what the accumulator can hold.
    always_comb begin
        if (int'(cfg_avg_log2) > MAX_LOG2) begin
            n_clip = NL_W'(MAX_LOG2);
        end else begin
            n_clip = NL_W'(cfg_avg_log2);
        end
    end

    assign win_last = (CNT_W'(1) << nlat_reg) - CNT_W'(1);
    assign sum      = acc_reg + ACC_W'(adc_data_in);

    always_comb begin
        avg_state_next = avg_state_reg;
        acc_next       = acc_reg;
        cnt_next       = cnt_reg;
        nlat_next      = nlat_reg;
        avg_data_next  = avg_data_reg;
        avg_valid_next = 1'b0;

        case (avg_state_reg)
            IDLE: begin
                if (cfg_en) begin
                    avg_state_next = ACC;
                    acc_next       = '0;
                    cnt_next       = '0;
                    nlat_next      = n_clip;
                end
            end
            ACC: begin
                if (!cfg_en) begin
                    // Partial window is thrown away; a strobe in this cycle is lost.
                    avg_state_next = IDLE;
                    acc_next       = '0;
                    cnt_next       = '0;
                end else if (adc_strb_in) begin
                    if (cnt_reg == win_last) begin
                        avg_data_next  = DW'(sum >> nlat_reg);
                        avg_valid_next = 1'b1;
                        acc_next       = '0;
                        cnt_next       = '0;
                        nlat_next      = n_clip;
                    end else begin
                        acc_next = sum;
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
            end
            default: begin
                avg_state_next = IDLE;
            end
        endcase
    end

    // Min and max are independent so a single sample can move both.
    always_comb begin
        min_next = min_reg;
        max_next = max_reg;
        if (clr_minmax) begin
            min_next = '1;
            max_next = '0;
        end else if (avg_state_reg == ACC && adc_strb_in) begin
            if (adc_data_in < min_reg) begin
                min_next = adc_data_in;
            end
            if (adc_data_in > max_reg) begin
                max_next = adc_data_in;
            end
        end
    end

    // Hysteresis is judged on the freshly registered average only.
    always_comb begin
        thr_state_next = thr_state_reg;
        if (avg_valid_reg) begin
            if (thr_state_reg == NORMAL && avg_data_reg > cfg_thr_hi) begin
                thr_state_next = ALARM;
            end else if (thr_state_reg == ALARM && avg_data_reg < cfg_thr_lo) begin
                thr_state_next = NORMAL;
            end
        end
    end

    always_comb begin
        irq_next = irq_reg;
        if (irq_clr) begin
            irq_next = 1'b0;
        end
        if (thr_state_reg == NORMAL && thr_state_next == ALARM) begin
            irq_next = 1'b1;
        end
    end

    always_ff @(posedge sys_slow_cbus_clk or negedge sys_slow_cbus_rst_n) begin
        if (!sys_slow_cbus_rst_n) begin
            avg_state_reg <= IDLE;
            thr_state_reg <= NORMAL;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            nlat_reg      <= '0;
            avg_data_reg  <= '0;
            avg_valid_reg <= 1'b0;
            min_reg       <= '1;
            max_reg       <= '0;
            irq_reg       <= 1'b0;
        end else begin
            avg_state_reg <= avg_state_next;
            thr_state_reg <= thr_state_next;
            acc_reg       <= acc_next;
            cnt_reg       <= cnt_next;
            nlat_reg      <= nlat_next;
            avg_data_reg  <= avg_data_next;
            avg_valid_reg <= avg_valid_next;
            min_reg       <= min_next;
            max_reg       <= max_next;
            irq_reg       <= irq_next;
        end
    end

    assign avg_data  = avg_data_reg;
    assign avg_valid = avg_valid_reg;
    assign min_data  = min_reg;
    assign max_data  = max_reg;
    assign thr_alarm = (thr_state_reg == ALARM);
    assign irq       = irq_reg;

endmodule

// File: tb/tb_soc_adc_sample_proc.sv
// Bench for soc_adc_sample_proc: directed scenarios plus random traffic,
// checked by a queue-based scoreboard fed from a behavioural model.
module tb_soc_adc_sample_proc;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] adc_data_in;
    logic       adc_strb_in;
    logic       cfg_en;
    logic [2:0] cfg_avg_log2;
    logic [9:0] cfg_thr_hi;
    logic [9:0] cfg_thr_lo;
    logic       clr_minmax;
    logic       irq_clr;
    logic [9:0] avg_data, min_data, max_data;
    logic       avg_valid, thr_alarm, irq;
    logic [9:0] av2_data, mn2_data, mx2_data;
    logic       av2_valid, al2, irq2;

    int total = 0;
    int bad   = 0;

    soc_adc_sample_proc #(.DW(10), .MAX_LOG2(7)) dut (
        .sys_slow_cbus_clk(clk), .sys_slow_cbus_rst_n(rst_n),
        .adc_data_in(adc_data_in), .adc_strb_in(adc_strb_in),
        .cfg_en(cfg_en), .cfg_avg_log2(cfg_avg_log2),
        .cfg_thr_hi(cfg_thr_hi), .cfg_thr_lo(cfg_thr_lo),
        .clr_minmax(clr_minmax), .irq_clr(irq_clr),
        .avg_data(avg_data), .avg_valid(avg_valid),
        .min_data(min_data), .max_data(max_data),
        .thr_alarm(thr_alarm), .irq(irq)
    );

    // Narrow-accumulator variant, used to check exponent clipping.
    soc_adc_sample_proc #(.DW(10), .MAX_LOG2(4)) dut2 (
        .sys_slow_cbus_clk(clk), .sys_slow_cbus_rst_n(rst_n),
        .adc_data_in(adc_data_in), .adc_strb_in(adc_strb_in),
        .cfg_en(cfg_en), .cfg_avg_log2(cfg_avg_log2),
        .cfg_thr_hi(cfg_thr_hi), .cfg_thr_lo(cfg_thr_lo),
        .clr_minmax(clr_minmax), .irq_clr(irq_clr),
        .avg_data(av2_data), .avg_valid(av2_valid),
        .min_data(mn2_data), .max_data(mx2_data),
        .thr_alarm(al2), .irq(irq2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    int  exp_q[$];
    int  m_win[$];
    bit  m_active = 0;
    int  m_n = 0;
    int  m_min = 1023;
    int  m_max = 0;
    bit  m_alarm = 0;
    bit  m_irq = 0;
    bit  m_pend = 0;
    int  m_pend_avg = 0;
    bit  m_rise = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            m_win.delete();
            m_active = 0;
            m_n = 0;
            m_min = 1023;
            m_max = 0;
            m_alarm = 0;
            m_irq = 0;
            m_pend = 0;
            m_rise = 0;
        end else begin
            m_rise = 0;
            if (m_pend) begin
                if (!m_alarm && m_pend_avg > int'(cfg_thr_hi)) begin
                    m_alarm = 1;
                    m_rise = 1;
                end else if (m_alarm && m_pend_avg < int'(cfg_thr_lo)) begin
                    m_alarm = 0;
                end
            end
            m_pend = 0;
            if (irq_clr) m_irq = 0;
            if (m_rise) m_irq = 1;

            if (clr_minmax) begin
                m_min = 1023;
                m_max = 0;
            end else if (m_active && adc_strb_in) begin
                if (int'(adc_data_in) < m_min) m_min = int'(adc_data_in);
                if (int'(adc_data_in) > m_max) m_max = int'(adc_data_in);
            end

            if (!m_active) begin
                if (cfg_en) begin
                    m_active = 1;
                    m_win.delete();
                    m_n = (int'(cfg_avg_log2) > 7) ? 7 : int'(cfg_avg_log2);
                end
            end else if (!cfg_en) begin
                m_active = 0;
                m_win.delete();
            end else if (adc_strb_in) begin
                m_win.push_back(int'(adc_data_in));
                if (m_win.size() == (1 << m_n)) begin
                    int s;
                    s = 0;
                    foreach (m_win[i]) s += m_win[i];
                    m_pend_avg = s / m_win.size();
                    m_pend = 1;
                    exp_q.push_back(m_pend_avg);
                    m_win.delete();
                    m_n = (int'(cfg_avg_log2) > 7) ? 7 : int'(cfg_avg_log2);
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (avg_valid) begin
                if (exp_q.size() == 0) begin
                    check("avg_unexpected_pulse", 1, 0);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    $display("txn avg_valid avg_data=%0d expected=%0d", avg_data, e);
                    check("avg_data", int'(avg_data), e);
                end
            end
            check("min_data", int'(min_data), m_min);
            check("max_data", int'(max_data), m_max);
            check("thr_alarm", int'(thr_alarm), int'(m_alarm));
            check("irq", int'(irq), int'(m_irq));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic s, input logic [9:0] d);
        adc_strb_in = s;
        adc_data_in = d;
        @(negedge clk);
        adc_strb_in = 1'b0;
        clr_minmax  = 1'b0;
        irq_clr     = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic enable(input logic [2:0] n);
        cfg_en = 1'b0;
        step(1'b0, 10'd0);
        cfg_avg_log2 = n;
        cfg_en = 1'b1;
        step(1'b0, 10'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int s16;
        logic [9:0] v;
        rst_n = 1'b0;
        adc_data_in = '0; adc_strb_in = 1'b0; cfg_en = 1'b0; cfg_avg_log2 = 3'd0;
        cfg_thr_hi = 10'd1023; cfg_thr_lo = 10'd0; clr_minmax = 1'b0; irq_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_avg_data", int'(avg_data), 0);
        check("rst_avg_valid", int'(avg_valid), 0);
        check("rst_min", int'(min_data), 1023);
        check("rst_max", int'(max_data), 0);
        check("rst_alarm", int'(thr_alarm), 0);
        check("rst_irq", int'(irq), 0);
        rst_n = 1'b1;
        step(1'b0, 10'd0);

        // N=2 window; strobes in IDLE must be ignored
        step(1'b1, 10'd999);
        enable(3'd2);
        step(1'b1, 10'd100); step(1'b0, 10'd0);
        step(1'b1, 10'd200); step(1'b0, 10'd0);
        step(1'b1, 10'd300);
        check("n2_no_pulse_after_3rd", int'(avg_valid), 0);
        step(1'b0, 10'd0);
        step(1'b1, 10'd401);
        check("n2_pulse", int'(avg_valid), 1);
        check("n2_avg", int'(avg_data), 250);
        step(1'b0, 10'd0);

        // N=0 back-to-back
        enable(3'd0);
        step(1'b1, 10'd5);
        check("n0_a", int'(avg_data), 5);
        step(1'b1, 10'd6);
        check("n0_b", int'(avg_data), 6);
        step(1'b1, 10'd7);
        check("n0_c", int'(avg_data), 7);
        step(1'b0, 10'd0);

        // N=7 full-scale, no overflow
        enable(3'd7);
        for (int i = 0; i < 128; i++) step(1'b1, 10'd1023);
        check("n7_avg", int'(avg_data), 1023);
        step(1'b0, 10'd0);

        // exponent clip on the narrow instance: window of 16
        do_reset();
        enable(3'd7);
        s16 = 0;
        for (int i = 0; i < 16; i++) begin
            v = 10'($urandom_range(0, 1023));
            s16 += int'(v);
            step(1'b1, v);
            if (i < 15) check("clip_early_pulse", int'(av2_valid), 0);
        end
        check("clip_pulse", int'(av2_valid), 1);
        check("clip_avg", int'(av2_data), s16 >> 4);
        step(1'b0, 10'd0);

        // hysteresis and irq
        do_reset();
        cfg_thr_hi = 10'd600; cfg_thr_lo = 10'd400;
        enable(3'd0);
        step(1'b1, 10'd500);
        step(1'b1, 10'd601);
        irq_clr = 1'b1;
        step(1'b1, 10'd500);
        check("thr_after_601", int'(thr_alarm), 1);
        check("irq_set_wins", int'(irq), 1);
        step(1'b1, 10'd399);
        step(1'b1, 10'd600);
        check("thr_after_399", int'(thr_alarm), 0);
        step(1'b0, 10'd0);
        check("thr_after_600", int'(thr_alarm), 0);
        check("irq_sticky", int'(irq), 1);
        irq_clr = 1'b1;
        step(1'b0, 10'd0);
        check("irq_cleared", int'(irq), 0);

        // min/max with clear coincident with a strobe
        clr_minmax = 1'b1;
        step(1'b0, 10'd0);
        step(1'b1, 10'd300); step(1'b1, 10'd50); step(1'b1, 10'd900);
        check("mm_min", int'(min_data), 50);
        check("mm_max", int'(max_data), 900);
        clr_minmax = 1'b1;
        step(1'b1, 10'd70);
        step(1'b1, 10'd80);
        check("mm_min_clr", int'(min_data), 80);
        check("mm_max_clr", int'(max_data), 80);

        // enable drop discards the partial window
        enable(3'd2);
        step(1'b1, 10'd200); step(1'b1, 10'd300);
        cfg_en = 1'b0;
        step(1'b0, 10'd0);
        cfg_en = 1'b1;
        step(1'b0, 10'd0);
        for (int i = 0; i < 4; i++) step(1'b1, 10'd10);
        check("en_drop_avg", int'(avg_data), 10);
        step(1'b0, 10'd0);

        // random traffic, including mid-window exponent changes
        enable(3'd1);
        for (int c = 0; c < 3000; c++) begin
            if (c % 300 == 0) begin
                cfg_thr_hi = 10'($urandom_range(450, 700));
                cfg_thr_lo = 10'($urandom_range(300, 600));
            end
            if ($urandom_range(0, 19) == 0) cfg_avg_log2 = 3'($urandom_range(0, 4));
            clr_minmax = ($urandom_range(0, 49) == 0);
            irq_clr    = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 149) == 0) begin
                cfg_en = 1'b0;
                step(1'b0, 10'd0);
                cfg_en = 1'b1;
                step(1'b0, 10'd0);
            end else begin
                step(1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)));
            end
        end

        // asynchronous reset in the middle of a window
        enable(3'd1);
        step(1'b1, 10'd700); step(1'b1, 10'd800);
        step(1'b1, 10'd900);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_avg_data", int'(avg_data), 0);
        check("async_avg_valid", int'(avg_valid), 0);
        check("async_min", int'(min_data), 1023);
        check("async_max", int'(max_data), 0);
        check("async_alarm", int'(thr_alarm), 0);
        check("async_irq", int'(irq), 0);
        @(negedge clk);
        rst_n = 1'b1;
        enable(3'd1);
        step(1'b1, 10'd20); step(1'b1, 10'd31);
        check("post_reset_avg", int'(avg_data), 25);
        repeat (3) step(1'b0, 10'd0);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
